// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants and the scheduler state encoding shared by
// the vblank access scheduler files.
package vga_timing_pkg;

    localparam int HD = 640;
    localparam int HF = 48;
    localparam int HB = 16;
    localparam int HR = 96;
    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VB = 33;
    localparam int VR = 2;

    localparam int H_TOTAL = HD + HF + HB + HR;
    localparam int V_TOTAL = VD + VF + VB + VR;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT,
        RELEASE
    } vbs_state_t;

endpackage

// File: rtl/vbs_rr_pick.sv
// Rotate-priority picker: returns the first set request at or after ptr,
// searching cyclically over N_REQ requesters.
module vbs_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

    logic [IDX_W:0] pos;

    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            if (req[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vblank_access_scheduler.sv
// Round-robin writer arbitration for the display register bank, granting only
// during vertical blanking. Optional per-requester miss counters: VBLANK_MISS_CNT_EN.
module vblank_access_scheduler
    import vga_timing_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int MAX_HOLD    = 800,
    parameter int GUARD_LINES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] abort,
    output logic             busy,
    output logic             frame_tick,
    output logic [7:0]       frame_cnt
`ifdef VBLANK_MISS_CNT_EN
    ,
    output logic [8*N_REQ-1:0] miss_cnt
`endif
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);

    localparam logic [9:0] WIN_START = 10'(VD);
    localparam logic [9:0] WIN_END   = 10'(V_TOTAL - GUARD_LINES);

    vbs_state_t        state_q, state_d;
    logic [IDX_W-1:0]  g_q, g_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  abort_q, abort_d;
    logic              frame_tick_q, frame_tick_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              win;
    logic              hold_expired;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    assign win          = (pixel_y >= WIN_START) && (pixel_y < WIN_END);
    assign hold_expired = p_tick && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    vbs_rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        abort_d    = '0;

        case (state_q)
            IDLE: begin
                if (win && |req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!win || !pick_valid) begin
                    state_d = IDLE;
                end else begin
                    g_d        = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A voluntary release outranks both revocation causes.
                if (!req[g_q]) begin
                    state_d = RELEASE;
                end else if (!win || hold_expired) begin
                    state_d     = RELEASE;
                    abort_d[g_q] = 1'b1;
                end else if (p_tick) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                ptr_d   = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = (win && |req) ? ARB : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        frame_tick_d = p_tick && (pixel_x == 10'd0) && (pixel_y == WIN_START);
        frame_cnt_d  = frame_cnt_q + {7'd0, frame_tick_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            g_q          <= '0;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            abort_q      <= '0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            abort_q      <= abort_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Decoded from registered state so reset removes the grant immediately.
    always_comb begin
        grant = '0;
        if (state_q == GRANT) begin
            grant[g_q] = 1'b1;
        end
    end

    assign busy       = (state_q == GRANT);
    assign abort      = abort_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef VBLANK_MISS_CNT_EN
    logic                 win_q;
    logic [N_REQ-1:0]     served_q, served_d;
    logic [8*N_REQ-1:0]   miss_q, miss_d;

    // A requester misses a window if it was still asking when the window
    // closed and never got the bank during it.
    always_comb begin
        served_d = served_q;
        miss_d   = miss_q;
        if ((state_q == ARB) && win && pick_valid) begin
            served_d[pick_idx]               = 1'b1;
            miss_d[8*int'(pick_idx) +: 8]    = 8'd0;
        end
        if (win_q && !win) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !served_q[i] && (miss_q[8*i +: 8] != 8'hFF)) begin
                    miss_d[8*i +: 8] = miss_q[8*i +: 8] + 8'd1;
                end
            end
            served_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q    <= 1'b0;
            served_q <= '0;
            miss_q   <= '0;
        end else begin
            win_q    <= win;
            served_q <= served_d;
            miss_q   <= miss_d;
        end
    end

    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_vblank_access_scheduler.sv
// Directed bench for vblank_access_scheduler: drives pixel coordinates directly
// and checks every cycle against a transaction-level model of the arbiter.
module tb_vblank_access_scheduler;

    localparam int N        = 3;
    localparam int MAXH     = 800;
    localparam int WIN_LO   = 480;
    localparam int WIN_HI   = 523;
    localparam int X_TOTAL  = 800;
    localparam int Y_TOTAL  = 525;

    logic       clk;
    logic       reset;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] abort;
    logic       busy;
    logic       frame_tick;
    logic [7:0] frame_cnt;
`ifdef VBLANK_MISS_CNT_EN
    logic [23:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int px = 0;
    int py = 0;
    bit alt_mode = 1'b0;

    // Model: who owns the bank, for how many ticks, and where the next search starts.
    int         m_owner = -1;
    int         m_ticks = 0;
    int         m_next  = 0;
    bit         m_cool  = 1'b0;
    bit         m_arm   = 1'b0;
    logic [2:0] m_abort = 3'b000;
    bit         m_ftick = 1'b0;
    int         m_fcnt  = 0;

    vblank_access_scheduler #(
        .N_REQ      (N),
        .MAX_HOLD   (MAXH),
        .GUARD_LINES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .req       (req),
        .grant     (grant),
        .abort     (abort),
        .busy      (busy),
        .frame_tick(frame_tick),
        .frame_cnt (frame_cnt)
`ifdef VBLANK_MISS_CNT_EN
        ,
        .miss_cnt  (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] exp_grant();
        return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ticks = 0;
        m_next  = 0;
        m_cool  = 1'b0;
        m_arm   = 1'b0;
        m_abort = 3'b000;
        m_ftick = 1'b0;
        m_fcnt  = 0;
    endfunction

    // Advance the model across the coming clock edge using the inputs now applied.
    function automatic void model_step();
        bit w;
        bit any;
        bit new_ftick;
        w         = (int'(pixel_y) >= WIN_LO) && (int'(pixel_y) < WIN_HI);
        any       = |req;
        new_ftick = p_tick && (pixel_x == 10'd0) && (int'(pixel_y) == WIN_LO);
        m_fcnt    = (m_fcnt + (m_ftick ? 1 : 0)) % 256;
        m_ftick   = new_ftick;
        m_abort   = 3'b000;
        if (m_owner >= 0) begin
            if (!req[m_owner] || !w || (p_tick && m_ticks == MAXH - 1)) begin
                if (req[m_owner]) m_abort[m_owner] = 1'b1;
                m_next  = (m_owner + 1) % N;
                m_owner = -1;
                m_cool  = 1'b1;
            end else if (p_tick) begin
                m_ticks++;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
            m_arm  = w && any;
        end else if (m_arm) begin
            m_arm = 1'b0;
            if (w) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_next + k) % N]) begin
                        m_owner = (m_next + k) % N;
                        m_ticks = 0;
                    end
                end
            end
        end else begin
            m_arm = w && any;
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset) model_reset();
            check_output("cmp_grant", grant, exp_grant());
            check_output("cmp_busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
            check_output("cmp_abort", abort, m_abort);
            check_output("cmp_frame_tick", frame_tick, m_ftick);
            check_output("cmp_frame_cnt", frame_cnt, m_fcnt);
            if (!reset) model_step();
        end
    end

    task automatic set_pos(input int x, input int y);
        px = x;
        py = y;
        pixel_x = 10'(px);
        pixel_y = 10'(py);
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (p_tick) begin
                px++;
                if (px == X_TOTAL) begin
                    px = 0;
                    py++;
                    if (py == Y_TOTAL) py = 0;
                end
            end
            p_tick  = alt_mode ? ~p_tick : 1'b1;
            pixel_x = 10'(px);
            pixel_y = 10'(py);
        end
    endtask

    task automatic wait_grant(output int cyc, input int budget);
        cyc = 0;
        while (grant == 3'b000 && cyc < budget) begin
            apply_stimulus(1);
            cyc++;
        end
        if (grant == 3'b000) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_grant: grant still 0, required a grant within %0d cycles", budget);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int         cyc;
        int         ft_seen;
        logic [2:0] order [4];
        int         who [4];
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        who   = '{0, 1, 2, 0};

        reset  = 1'b0;
        p_tick = 1'b0;
        req    = 3'b000;
        set_pos(0, 0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_grant", grant, 0);
        check_output("rst_abort", abort, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_frame_tick", frame_tick, 0);
        check_output("rst_frame_cnt", frame_cnt, 0);
        reset  = 1'b0;
        p_tick = 1'b1;

        $display("[TB] request outside the window is held until y=480");
        set_pos(0, 100);
        req = 3'b001;
        apply_stimulus(50);
        check_output("t1_pending", grant, 0);
        set_pos(790, 479);
        apply_stimulus(10);
        apply_stimulus(1);
        check_output("t1_arb_cycle", grant, 0);
        check_output("t1_frame_tick", frame_tick, 1);
        apply_stimulus(1);
        check_output("t1_grant", grant, 3'b001);
        check_output("t1_busy", busy, 1);
        check_output("t1_frame_cnt", frame_cnt, 1);
        req = 3'b000;
        apply_stimulus(1);
        check_output("t1_drop_grant", grant, 0);
        check_output("t1_drop_busy", busy, 0);
        check_output("t1_drop_abort", abort, 0);
        pulse_reset();

        $display("[TB] round robin with three requesters");
        set_pos(0, 490);
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(cyc, 20);
            check_output("t2_order", grant, order[i]);
            check_output("t2_gap", cyc, 2);
            apply_stimulus(10);
            req[who[i]] = 1'b0;
            apply_stimulus(1);
            check_output("t2_release", grant, 0);
            if (i < 3) req[who[i]] = 1'b1;
            else req = 3'b110;
        end

        $display("[TB] hold timeout");
        wait_grant(cyc, 20);
        check_output("t3_grant", grant, 3'b010);
        check_output("t3_gap", cyc, 2);
        cyc = 0;
        while (grant == 3'b010 && cyc < 900) begin
            apply_stimulus(1);
            cyc++;
        end
        check_output("t3_hold_len", cyc, MAXH);
        check_output("t3_abort", abort, 3'b010);
        check_output("t3_grant_drop", grant, 0);
        apply_stimulus(1);
        check_output("t3_abort_pulse", abort, 0);
        wait_grant(cyc, 20);
        check_output("t3_next_grant", grant, 3'b100);
        req = 3'b000;
        apply_stimulus(3);

        $display("[TB] hold timeout with p_tick at half rate");
        req = 3'b001;
        alt_mode = 1'b1;
        wait_grant(cyc, 20);
        check_output("t3b_grant", grant, 3'b001);
        cyc = 0;
        while (grant != 3'b000 && cyc < 2000) begin
            apply_stimulus(1);
            cyc++;
        end
        check_output("t3b_abort", abort, 3'b001);
        alt_mode = 1'b0;
        req = 3'b000;
        apply_stimulus(3);

        $display("[TB] window close revokes the grant");
        req = 3'b001;
        set_pos(780, 522);
        wait_grant(cyc, 20);
        check_output("t4_grant", grant, 3'b001);
        cyc = 0;
        while (py != 523 && cyc < 100) begin
            apply_stimulus(1);
            cyc++;
        end
        check_output("t4_reach_523", py, 523);
        check_output("t4_grant_at_523", grant, 3'b001);
        apply_stimulus(1);
        check_output("t4_revoked", grant, 0);
        check_output("t4_abort", abort, 3'b001);
        check_output("t4_busy", busy, 0);
        req = 3'b011;
        set_pos(790, 524);
        apply_stimulus(20);
        check_output("t4_pending_next_frame", grant, 0);
        set_pos(790, 479);
        wait_grant(cyc, 30);
        check_output("t4_next_frame_latency", cyc, 12);
        check_output("t4_next_frame_grant", grant, 3'b010);
        req = 3'b000;
        apply_stimulus(3);

        $display("[TB] reset in the middle of a grant");
        req = 3'b111;
        set_pos(0, 490);
        wait_grant(cyc, 20);
        check_output("t6_pre_grant", grant, 3'b100);
        reset = 1'b1;
        #1;
        check_output("t6_grant", grant, 0);
        check_output("t6_busy", busy, 0);
        check_output("t6_abort", abort, 0);
        check_output("t6_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_grant(cyc, 20);
        check_output("t6_first_grant", grant, 3'b001);
        check_output("t6_gap", cyc, 2);
        req = 3'b000;
        apply_stimulus(3);

        $display("[TB] 256 frames of frame_tick");
        ft_seen = 0;
        for (int f = 0; f < 256; f++) begin
            set_pos(797, 479);
            for (int j = 0; j < 7; j++) begin
                apply_stimulus(1);
                if (frame_tick) ft_seen++;
            end
            if (f == 0) check_output("t5_first_frame_cnt", frame_cnt, 1);
        end
        check_output("t5_tick_count", ft_seen, 256);
        check_output("t5_frame_cnt_wrap", frame_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vblank_access_scheduler.md
Name: vblank_access_scheduler

Overview:
- Round-robin scheduler granting N requesters (RTC readout, user edit, cursor logic) exclusive write access to the shared display register bank.
- Grants only inside the vertical-blanking window, so on-screen content never tears.
- Consumes pixel_x, pixel_y and p_tick from the VGA sync generator; sits between the sync generator and the display register bank's write mux.

Parameters:
- N_REQ, 3: number of requesters (2..8).
- MAX_HOLD, 800: maximum grant length in p_ticks (one line).
- GUARD_LINES, 2: lines before V_TOTAL after which no new grants are issued and any open grant is revoked.

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-high reset.
- p_tick  in  1: pixel-rate enable from the sync generator.
- pixel_x  in  10: current horizontal count.
- pixel_y  in  10: current vertical count.
- req  in  N_REQ: level request per requester; held until done.
- grant  out  N_REQ: one-hot exclusive grant.
- abort  out  N_REQ: one-clk pulse, grant revoked (timeout or window close).
- busy  out  1: high while any grant is held.
- frame_tick  out  1: one-clk pulse at blanking start.
- frame_cnt  out  8: frame counter, wraps.

Behaviour:
- Reset value of every output is 0; rr pointer = 0; state IDLE. Assertion clears everything immediately (grant drops asynchronously).
- win = (pixel_y >= VD) && (pixel_y < V_TOTAL - GUARD_LINES), combinational; 480..522 with defaults.
- IDLE: if win && |req, go to ARB.
- ARB (one clk):
  - If !win, go to IDLE.
  - Otherwise pick the first req bit at or after the pointer, cyclically.
  - If none is set, go to IDLE; else latch index g, load hold_cnt = 0, go to GRANT.
- GRANT: grant[g] = 1, busy = 1. hold_cnt increments on each p_tick. Exit priority, highest first:
  - (a) req[g] = 0: go to RELEASE, no abort.
  - (b) !win: go to RELEASE, abort[g] pulse.
  - (c) p_tick && hold_cnt == MAX_HOLD-1: go to RELEASE, abort[g] pulse.
- RELEASE (one clk): grant = 0, busy = 0; pointer = (g+1) mod N_REQ. If win && |req go to ARB, else IDLE.
- Latency:
  - Grant is asserted on the second clk edge after req is seen in IDLE with win high.
  - Grant drops on the first edge after req falls.
- Consecutive grants are separated by at least 2 idle-grant clks (RELEASE + ARB).
- Requests outside win are held pending, never lost; they are served when win next opens.
- frame_tick = p_tick && pixel_x == 0 && pixel_y == VD, registered (1-clk delay). frame_cnt increments on frame_tick, 255 wraps to 0.
- hold_cnt width = $clog2(MAX_HOLD); it must never wrap.
- grant is always one-hot or zero; abort only pulses for the currently granted index.

Optional Feature:
- Macro VBLANK_MISS_CNT_EN.
- Defined: adds output miss_cnt [8*N_REQ-1:0], one 8-bit saturating counter per requester.
  - A counter increments when win falls while that req is high and that requester received no grant during the window.
  - The counter clears on that requester's next grant.
- Undefined: the port and the logic are absent.

Decomposition:
- Package vga_timing_pkg holds:
  - HD=640, HF=48, HB=16, HR=96, VD=480, VF=10, VB=33, VR=2.
  - H_TOTAL=800, V_TOTAL=525.
  - The state enum {IDLE, ARB, GRANT, RELEASE}.
- One sub-module, vbs_rr_pick: combinational rotate-priority picker (req, ptr) -> (valid, idx). The FSM and counters stay in the top.

Test Plan:
- req=3'b001 asserted at pixel_y=100 -> no grant until pixel_y=480; grant=001 two clks after the window opens; drop req -> grant=0 next edge, busy=0.
- req=3'b111 held through the window, each requester releasing after 10 p_ticks -> grant order 001, 010, 100, 001...; never two bits set.
- req[1] held past MAX_HOLD=800 p_ticks -> abort=010 one-clk pulse, grant drops; next grant goes to requester 2 if pending.
- Grant active at pixel_y=522, pixel_x=799, p_tick -> at pixel_y=523 grant=0 with abort pulse; new req is not served until the next frame's y=480.
- 256 frames simulated -> frame_tick pulses once per frame at y=480/x=0; frame_cnt returns to 0.
- reset pulsed mid-GRANT -> grant, busy, abort, frame_cnt = 0 immediately; pointer back to 0; the first post-reset grant goes to requester 0 with req=111.
